// File: rtl/minmax_pkg.sv
// Shared definitions for the frame min/max tracker.
//   state_e     : FSM state encoding (IDLE / ACCUM / DONE)
//   *_DEF       : default sample width, frame length limit and count width
package minmax_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int WIDTH_DEF   = 4;
  localparam int MAX_LEN_DEF = 15;
  localparam int CNT_W_DEF   = 4;

endpackage : minmax_pkg

// File: rtl/frame_minmax_tracker_cmp.sv
// signed_cmp: combinational two's-complement comparator built on a single
// subtractor d = a + ~b + 1. Overflow is the XOR of the carry into and the
// carry out of the sign bit, which corrects the sign of d when a - b
// leaves the representable range (e.g. 7 - (-8)).
// Ports:
//   a, b : signed operands, WIDTH bits
//   eq   : a == b
//   gt   : a >  b
//   lt   : a <  b
module signed_cmp #(
  parameter int WIDTH = 4
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    eq,
  output logic                    gt,
  output logic                    lt
);

  logic [WIDTH:0]   full_sum;
  logic [WIDTH-1:0] low_sum;
  logic [WIDTH-1:0] diff;
  logic             carry_out;
  logic             carry_msb;
  logic             ovf;

  // Full-width subtract, plus a copy of the lower bits to recover the
  // carry into the MSB.
  assign full_sum  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign low_sum   = {1'b0, a[WIDTH-2:0]} + {1'b0, ~b[WIDTH-2:0]}
                   + {{(WIDTH-1){1'b0}}, 1'b1};
  assign diff      = full_sum[WIDTH-1:0];
  assign carry_out = full_sum[WIDTH];
  assign carry_msb = low_sum[WIDTH-1];
  assign ovf       = carry_msb ^ carry_out;

  assign eq = (diff == '0);
  assign lt = diff[WIDTH-1] ^ ovf;
  assign gt = ~eq & ~lt;

endmodule : signed_cmp

// File: rtl/frame_minmax_tracker.sv
// frame_minmax_tracker: consumes a frame of signed samples over a
// valid/ready handshake, tracks the running max/min and the index of their
// first occurrence, and presents one result record per frame.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid/in_ready   : input handshake, in_ready decoded from state only
//   in_data, in_last    : signed sample, final-sample-of-frame flag
//   out_valid/out_ready : result handshake, out_valid decoded from state only
//   max_val, min_val    : frame extremes
//   max_idx, min_idx    : 0-based position of first occurrence
//   count               : samples accepted in the frame
//   trunc               : frame closed by the length limit, not by in_last
module frame_minmax_tracker
  import minmax_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] max_val,
  output logic signed [WIDTH-1:0] min_val,
  output logic        [CNT_W-1:0] max_idx,
  output logic        [CNT_W-1:0] min_idx,
  output logic        [CNT_W-1:0] count,
  output logic                    trunc
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_LEN);
  localparam bit               ONE_SHOT = (MAX_LEN == 1);

  state_e state_q, state_d;

  logic signed [WIDTH-1:0] max_q, max_d;
  logic signed [WIDTH-1:0] min_q, min_d;
  logic        [CNT_W-1:0] max_idx_q, max_idx_d;
  logic        [CNT_W-1:0] min_idx_q, min_idx_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic                    trunc_q, trunc_d;

  logic                    accept;
  logic        [CNT_W-1:0] cnt_inc;
  logic                    max_gt, max_eq, max_lt;
  logic                    min_gt, min_eq, min_lt;
  logic                    unused_cmp;

  assign accept  = in_valid && in_ready;
  assign cnt_inc = cnt_q + CNT_W'(1);

  signed_cmp #(.WIDTH(WIDTH)) u_cmp_max (
    .a  (in_data),
    .b  (max_q),
    .eq (max_eq),
    .gt (max_gt),
    .lt (max_lt)
  );

  signed_cmp #(.WIDTH(WIDTH)) u_cmp_min (
    .a  (in_data),
    .b  (min_q),
    .eq (min_eq),
    .gt (min_gt),
    .lt (min_lt)
  );

  assign unused_cmp = ^{max_eq, max_lt, min_eq, min_gt};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = (in_last || ONE_SHOT) ? DONE : ACCUM;
      end
      ACCUM: begin
        if (accept && (in_last || cnt_inc == MAX_CNT)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs depend on state only, never on in_valid/out_ready.
  always_comb begin
    in_ready  = (state_q != DONE);
    out_valid = (state_q == DONE);
  end

  // Result datapath next-state: first sample seeds, later samples compare
  // strictly so ties keep the first occurrence.
  always_comb begin
    max_d     = max_q;
    min_d     = min_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
    cnt_d     = cnt_q;
    trunc_d   = trunc_q;
    if (accept) begin
      if (state_q == IDLE) begin
        max_d     = in_data;
        min_d     = in_data;
        max_idx_d = '0;
        min_idx_d = '0;
        cnt_d     = CNT_W'(1);
        trunc_d   = 1'b0;
      end else begin
        if (max_gt) begin
          max_d     = in_data;
          max_idx_d = cnt_q;
        end
        if (min_lt) begin
          min_d     = in_data;
          min_idx_d = cnt_q;
        end
        cnt_d   = cnt_inc;
        // in_last wins over the length limit when both land together.
        trunc_d = !in_last && (cnt_inc == MAX_CNT);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
      cnt_q     <= '0;
      trunc_q   <= 1'b0;
    end else begin
      max_q     <= max_d;
      min_q     <= min_d;
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
      cnt_q     <= cnt_d;
      trunc_q   <= trunc_d;
    end
  end

  assign max_val = max_q;
  assign min_val = min_q;
  assign max_idx = max_idx_q;
  assign min_idx = min_idx_q;
  assign count   = cnt_q;
  assign trunc   = trunc_q;

endmodule : frame_minmax_tracker
